seq_mul_div: RTL and testbench

//  Iterative RV32M multiply/divide unit beside the single-cycle integer adder in the EXU.

---
 rtl/npc_pkg.sv | 22 ++
 rtl/md_addsub.sv | 21 ++
 rtl/seq_mul_div.sv | 247 ++++++++++++++++++++++++
 tb/tb_seq_mul_div.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/npc_pkg.sv
// Shared definitions for the EXU multiply/divide unit.
//   MD_OP_*    : RV32M funct3 encodings as presented on the op port
//   md_state_t : control states of the iterative unit
package npc_pkg;

  localparam logic [2:0] MD_OP_MUL    = 3'b000;
  localparam logic [2:0] MD_OP_MULH   = 3'b001;
  localparam logic [2:0] MD_OP_MULHSU = 3'b010;
  localparam logic [2:0] MD_OP_MULHU  = 3'b011;
  localparam logic [2:0] MD_OP_DIV    = 3'b100;
  localparam logic [2:0] MD_OP_DIVU   = 3'b101;
  localparam logic [2:0] MD_OP_REM    = 3'b110;
  localparam logic [2:0] MD_OP_REMU   = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } md_state_t;

endpackage

// File: rtl/md_addsub.sv
// Combinational W-bit adder/subtractor: sub=0 -> a+b, sub=1 -> a-b.
//   a, b  : operands
//   sub   : select subtraction (two's complement of b with carry-in)
//   sum   : W-bit result
//   carry : carry out; for subtraction 1 means no borrow (a >= b)
module md_addsub #(
  parameter int W = 33
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  output logic [W-1:0] sum,
  output logic         carry
);

  logic [W-1:0] b_eff;

  assign b_eff = sub ? ~b : b;
  assign {carry, sum} = {1'b0, a} + {1'b0, b_eff} + {{W{1'b0}}, sub};

endmodule

// File: rtl/seq_mul_div.sv
// Iterative RV32M multiply/divide unit. One bit of shift-add multiplication or
// restoring division per cycle through a single (XLEN+1)-bit adder; a final FIX
// cycle applies the sign correction through the same adder.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid/in_ready   : request handshake (in_ready only while idle)
//   op, src1, src2      : funct3 and operands
//   flush               : abandon any in-flight or pending operation
//   out_valid/out_ready : result handshake
//   result              : registered rd value, stable until taken
module seq_mul_div import npc_pkg::*; #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);
  localparam int W  = XLEN + 1;
  localparam logic [XLEN-1:0] ONE     = {{(XLEN-1){1'b0}}, 1'b1};
  localparam logic [XLEN-1:0] ZERO    = {XLEN{1'b0}};
  localparam logic [XLEN-1:0] ONES    = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  md_state_t       state_r, state_nx;
  logic [2:0]      op_r;
  logic            sgn_diff_r;   // product/quotient must be negated
  logic            rem_neg_r;    // dividend was negative
  logic [CW-1:0]   cnt_r;
  logic [2*XLEN-1:0] acc_r;      // product, or {remainder, quotient}
  logic [XLEN-1:0] opd_r;        // multiplicand magnitude, or divisor magnitude
  logic [XLEN-1:0] result_r;

  logic [XLEN-1:0] acc_hi, acc_lo;
  logic            sign1, sign2, neg1, neg2;
  logic [XLEN-1:0] abs1, abs2;
  logic            div_zero, div_ovf, fast;
  logic [XLEN-1:0] fast_val;
  logic [XLEN-1:0] fix_x;
  logic            fix_neg, fix_inc;
  logic [W-1:0]    add_a, add_b, add_sum;
  logic            add_sub, add_carry;

  assign acc_hi    = acc_r[2*XLEN-1:XLEN];
  assign acc_lo    = acc_r[XLEN-1:0];
  assign in_ready  = (state_r == IDLE);
  assign out_valid = (state_r == DONE);
  assign result    = result_r;

  // Decode signedness, magnitudes and fast-path result of the presented request.
  always_comb begin
    sign1 = 1'b0;
    sign2 = 1'b0;
    if (op[2]) begin
      sign1 = ~op[0];
      sign2 = ~op[0];
    end else begin
      sign1 = (op != MD_OP_MULHU);
      sign2 = ~op[1];
    end
    neg1     = sign1 & src1[XLEN-1];
    neg2     = sign2 & src2[XLEN-1];
    abs1     = neg1 ? (~src1 + ONE) : src1;
    abs2     = neg2 ? (~src2 + ONE) : src2;
    div_zero = (src2 == ZERO);
    div_ovf  = ~op[0] & (src1 == MIN_NEG) & (src2 == ONES);
    fast     = op[2] & (div_zero | div_ovf);
    if (div_zero) begin
      fast_val = op[1] ? src1 : ONES;
    end else begin
      fast_val = op[1] ? ZERO : src1;
    end
  end

  // Pick the word FIX returns and how to negate it. The high half of a negated
  // product is ~hi plus the carry out of negating lo, which is 1 only when lo==0.
  always_comb begin
    fix_x   = acc_lo;
    fix_neg = 1'b0;
    fix_inc = 1'b1;
    case (op_r)
      MD_OP_MUL: begin
        fix_x   = acc_lo;
        fix_neg = sgn_diff_r;
      end
      MD_OP_MULH, MD_OP_MULHSU, MD_OP_MULHU: begin
        fix_x   = acc_hi;
        fix_neg = sgn_diff_r;
        fix_inc = (acc_lo == ZERO);
      end
      MD_OP_DIV, MD_OP_DIVU: begin
        fix_x   = acc_lo;
        fix_neg = sgn_diff_r;
      end
      MD_OP_REM, MD_OP_REMU: begin
        fix_x   = acc_hi;
        fix_neg = rem_neg_r;
      end
      default: begin
        fix_x   = acc_lo;
        fix_neg = 1'b0;
      end
    endcase
  end

  // Steer the shared adder: iteration step in CALC, negation in FIX.
  always_comb begin
    add_a   = {W{1'b0}};
    add_b   = {W{1'b0}};
    add_sub = 1'b0;
    case (state_r)
      CALC: begin
        if (op_r[2]) begin
          add_a   = {acc_hi, acc_lo[XLEN-1]};
          add_b   = {1'b0, opd_r};
          add_sub = 1'b1;
        end else begin
          add_a   = {1'b0, acc_hi};
          add_b   = acc_lo[0] ? {1'b0, opd_r} : {W{1'b0}};
          add_sub = 1'b0;
        end
      end
      FIX: begin
        add_a = {1'b0, ~fix_x};
        add_b = {{XLEN{1'b0}}, fix_inc};
      end
      default: begin
        add_a = {W{1'b0}};
      end
    endcase
  end

  md_addsub #(.W(W)) u_addsub (
    .a     (add_a),
    .b     (add_b),
    .sub   (add_sub),
    .sum   (add_sum),
    .carry (add_carry)
  );

  // Next-state logic; flush overrides everything.
  always_comb begin
    state_nx = state_r;
    if (flush) begin
      state_nx = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            state_nx = fast ? DONE : CALC;
          end else begin
            state_nx = IDLE;
          end
        end
        CALC: begin
          if (cnt_r == {CW{1'b0}}) begin
            state_nx = FIX;
          end else begin
            state_nx = CALC;
          end
        end
        FIX:  state_nx = DONE;
        DONE: begin
          if (out_ready) begin
            state_nx = IDLE;
          end else begin
            state_nx = DONE;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx;
    end
  end

  // Datapath: capture on acceptance, iterate in CALC, sign-correct in FIX.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_r       <= 3'd0;
      sgn_diff_r <= 1'b0;
      rem_neg_r  <= 1'b0;
      cnt_r      <= {CW{1'b0}};
      acc_r      <= {(2*XLEN){1'b0}};
      opd_r      <= ZERO;
      result_r   <= ZERO;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid && !flush) begin
            op_r       <= op;
            sgn_diff_r <= neg1 ^ neg2;
            rem_neg_r  <= neg1;
            cnt_r      <= CW'(XLEN - 1);
            if (op[2]) begin
              acc_r <= {ZERO, abs1};
              opd_r <= abs2;
            end else begin
              acc_r <= {ZERO, abs2};
              opd_r <= abs1;
            end
            if (fast) begin
              result_r <= fast_val;
            end
          end
        end
        CALC: begin
          if (cnt_r != {CW{1'b0}}) begin
            cnt_r <= cnt_r - {{(CW-1){1'b0}}, 1'b1};
          end
          if (op_r[2]) begin
            // No borrow means the trial subtraction fits: keep it, quotient bit 1.
            if (add_carry) begin
              acc_r <= {add_sum[XLEN-1:0], acc_lo[XLEN-2:0], 1'b1};
            end else begin
              acc_r <= {add_a[XLEN-1:0], acc_lo[XLEN-2:0], 1'b0};
            end
          end else begin
            acc_r <= {add_sum, acc_lo[XLEN-1:1]};
          end
        end
        FIX: begin
          result_r <= fix_neg ? add_sum[XLEN-1:0] : fix_x;
        end
        default: begin
          result_r <= result_r;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mul_div.sv
// Directed bench for seq_mul_div with an arithmetic reference model and a
// per-cycle result comparator.
module tb_seq_mul_div;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  op = 3'd0;
  logic [31:0] src1 = 32'd0;
  logic [31:0] src2 = 32'd0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
    int          hold;
  } vec_t;
  vec_t vecs[$];

  seq_mul_div #(.XLEN(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .src1      (src1),
    .src2      (src2),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // RV32M semantics from 64-bit arithmetic.
  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a,
                                        input logic [31:0] b);
    longint sa, sb;
    logic [63:0] p;
    logic [31:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r  = 32'd0;
    case (f)
      3'd0: begin p = sa * sb; r = p[31:0]; end
      3'd1: begin p = sa * sb; r = p[63:32]; end
      3'd2: begin p = sa * longint'({32'd0, b}); r = p[63:32]; end
      3'd3: begin p = {32'd0, a} * {32'd0, b}; r = p[63:32]; end
      3'd4: begin
        if (b == 32'd0) r = 32'hFFFF_FFFF;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = a;
        else begin p = sa / sb; r = p[31:0]; end
      end
      3'd5: r = (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 32'd0) r = a;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'd0;
        else begin p = sa % sb; r = p[31:0]; end
      end
      default: r = (b == 32'd0) ? a : a % b;
    endcase
    return r;
  endfunction

  // Result comparator: every cycle a result is offered it must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_out_valid: got result %h, expected no output", result);
      end else begin
        check("result_vs_model", result, exp_q[0]);
        check("in_ready_while_done", {31'd0, in_ready}, 32'd0);
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic accept(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    check("in_ready_before_req", {31'd0, in_ready}, 32'd1);
    op = f; src1 = a; src2 = b; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    exp_q.push_back(model(f, a, b));
  endtask

  task automatic run_vec(input vec_t v);
    int lat;
    check($sformatf("model_pin_op%0d", v.f), model(v.f, v.a, v.b), v.exp);
    accept(v.f, v.a, v.b);
    lat = 1;
    while (!out_valid && lat < 60) begin
      @(posedge clk);
      #1 lat++;
    end
    check($sformatf("latency_op%0d", v.f), lat, v.lat);
    check($sformatf("result_lit_op%0d", v.f), result, v.exp);
    for (int i = 0; i < v.hold; i++) begin
      @(posedge clk);
      #1;
      check("hold_out_valid", {31'd0, out_valid}, 32'd1);
      check("hold_result", result, v.exp);
      check("hold_in_ready", {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    check("after_take_out_valid", {31'd0, out_valid}, 32'd0);
    check("after_take_in_ready", {31'd0, in_ready}, 32'd1);
  endtask

  task automatic expect_silence(input string name, input int cycles);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1 if (out_valid) seen = 1'b1;
    end
    check(name, {31'd0, seen}, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    vecs.push_back('{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 34, 0});
    vecs.push_back('{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34, 0});
    vecs.push_back('{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 34, 0});
    vecs.push_back('{3'd2, 32'hFFFF_FFFF, 32'd2,          32'hFFFF_FFFF, 34, 0});
    vecs.push_back('{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34, 0});
    vecs.push_back('{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 34, 0});
    vecs.push_back('{3'd4, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFD, 34, 0});
    vecs.push_back('{3'd6, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF, 34, 0});
    vecs.push_back('{3'd6, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 34, 0});
    vecs.push_back('{3'd5, 32'd100,        32'd7,          32'd14,        34, 3});
    vecs.push_back('{3'd7, 32'd100,        32'd7,          32'd2,         34, 0});
    vecs.push_back('{3'd5, 32'hFFFF_FFFF, 32'd1,          32'hFFFF_FFFF, 34, 0});
    vecs.push_back('{3'd5, 32'd5,          32'd0,          32'hFFFF_FFFF, 1,  0});
    vecs.push_back('{3'd6, 32'd5,          32'd0,          32'd5,         1,  0});
    vecs.push_back('{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1,  2});
    vecs.push_back('{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1,  0});

    // Reset state.
    #2;
    check("reset_in_ready", {31'd0, in_ready}, 32'd1);
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("reset_result", result, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Flush while idle leaves the unit idle.
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    check("idle_flush_in_ready", {31'd0, in_ready}, 32'd1);
    check("idle_flush_out_valid", {31'd0, out_valid}, 32'd0);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Flush mid-CALC with a competing request that must not be taken.
    accept(3'd0, 32'd123, 32'd456);
    repeat (10) @(posedge clk);
    #1;
    flush = 1'b1; in_valid = 1'b1; op = 3'd5; src1 = 32'd5; src2 = 32'd0;
    @(posedge clk);
    #1 flush = 1'b0; in_valid = 1'b0;
    exp_q.delete();
    check("flush_in_ready", {31'd0, in_ready}, 32'd1);
    check("flush_out_valid", {31'd0, out_valid}, 32'd0);
    expect_silence("flush_no_output", 40);

    // Async reset mid-CALC.
    accept(3'd4, 32'd1000, 32'd3);
    repeat (5) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("midreset_in_ready", {31'd0, in_ready}, 32'd1);
    check("midreset_out_valid", {31'd0, out_valid}, 32'd0);
    check("midreset_result", result, 32'd0);
    exp_q.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    expect_silence("reset_no_output", 40);

    // Unit works again after the abort.
    run_vec('{3'd7, 32'd1000, 32'd3, 32'd1, 34, 0});

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
